drive_command_sequencer: RTL and testbench
==========================================

# drive_command_sequencer

Command-side initiator for the H-bridge driver: accepts rover motion commands over a valid/ready handshake and drives the H-bridge's `movingDirection[3:0]` and `motorSpeed[5:0]` inputs. It enforces three rules:
- per-tread speed ramping;
- a braked dead time before any direction reversal;
- a latched over-current shutdown.

It sits between the command source (UART/remote decoder) and the H-bridge block.

## Interface
- `RAMP_DIV`, 2000: clock cycles per one-step speed change, per tread.
- `DEADTIME_CYCLES`, 1000: cycles HARD_STOP is held before a new direction is applied.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cmdValid` in 1: command present.
- `cmdReady` out 1: block can accept a command.
- `cmdDirection` in 4: requested direction code.
- `cmdSpeed` in 6: target speed; [2:0] tread 1, [5:3] tread 2.
- `currentSensing` in 6: asynchronous over-current flags; any nonzero bit is a fault.
- `faultClear` in 1: single-cycle fault acknowledge.
- `movingDirection` out 4: to the H-bridge.
- `motorSpeed` out 6: to the H-bridge, same tread split as `cmdSpeed`.
- `busy` out 1: state is not IDLE.
- `fault` out 1: over-current latched.

## Operation
- Direction codes:
  - INERTIAL_STOP 0000
  - HARD_STOP 1111
  - FORWARD 0110
  - REVERSE 1001
  - TURN_RIGHT 0101
  - TURN_LEFT 1010
- Any other code is treated as INERTIAL_STOP with target 0.
- States: IDLE, RAMP, DEADTIME, FAULT.
- Handshake:
  - A transfer occurs on a rising edge with `cmdValid && cmdReady`.
  - `cmdReady` = (state is IDLE or RAMP) and `reset` is low; it is a function of state only.
- Accepted command, first matching rule applies:
  1. Stop code (INERTIAL_STOP or HARD_STOP):
     - Apply the code with `motorSpeed`=0 at once, no ramp.
     - Go to IDLE.
  2. Same direction as current `movingDirection`:
     - Retarget both treads.
     - Go to RAMP; the ramp counter restarts.
  3. Different direction and `motorSpeed`==0:
     - Apply the new direction, speed stays 0.
     - Go to RAMP.
  4. Different direction and `motorSpeed`!=0:
     - Output HARD_STOP with speed 0.
     - Go to DEADTIME and store the pending direction and target.
- DEADTIME:
  - After `DEADTIME_CYCLES`, apply the pending direction with speed 0.
  - Go to RAMP; the ramp counter starts fresh.
- RAMP:
  - Every `RAMP_DIV` cycles, each tread independently moves one step toward its target, up or down.
  - Each 3-bit tread speed stays within 000..111; it never wraps or overshoots.
  - When both treads equal their targets, go to IDLE on that same edge.
- FAULT entry:
  - `currentSensing` passes through a 2-flop synchronizer.
  - A nonzero synced value, in any state, moves the block to FAULT on the next edge.
  - Outputs in FAULT: INERTIAL_STOP, speed 0, `fault`=1, `cmdReady`=0.
- FAULT exit:
  - `faultClear` while synced current is 0 goes to IDLE with outputs INERTIAL_STOP, speed 0, `fault`=0.
  - `faultClear` while synced current is nonzero is ignored.
- Simultaneous events:
  - Fault detection beats an accepted command. The handshake completes but the command is discarded.
  - Fault detection during DEADTIME discards the pending command.

## Timing
- Reset values (asynchronous):
  - state IDLE
  - `movingDirection` 0000, `motorSpeed` 0
  - `fault` 0, `busy` 0
  - `cmdReady` 0 while `reset` is high, 1 from the first cycle after release
  - synchronizer flops 0, counters 0, pending registers 0
- All outputs are registered except `cmdReady`.
- For a transfer at edge k:
  - Stop and direction outputs change at edge k.
  - The first speed step occurs at edge k+`RAMP_DIV`.
- Reversal accepted at edge k:
  - HARD_STOP is held for edges k .. k+`DEADTIME_CYCLES`-1.
  - The new direction appears at edge k+`DEADTIME_CYCLES`.
  - The first step occurs `RAMP_DIV` cycles after that.
- Fault latency: 3 edges from `currentSensing` change to outputs (2 synchronizer edges + 1 state edge).
- Reset asserted mid-ramp or mid-deadtime: outputs clear immediately, and the pending command is lost.

## Structure
- Shared package `rover_drive_pkg`:
  - direction code constants
  - state enum
  - tread speed width (3) and tread count (2)
- Top level holds:
  - the FSM
  - the ramp and deadtime counter, one counter shared by both
  - the pending-command registers
  - the synchronizer
- Sub-module `tread_speed_ramp`, instantiated twice:
  - inputs: 3-bit current speed, target, step strobe
  - outputs: next speed and `atTarget`

## Test plan
Bench uses `RAMP_DIV`=4 and `DEADTIME_CYCLES`=10.
1. Reset pulse mid-simulation: outputs go to 0000 / 000000 asynchronously, with `cmdReady` 0 during reset and 1 one cycle after release.
2. From stop, send FORWARD with 111_111 at edge k: direction becomes 0110 at k, speed is 001_001 at k+4 and 111_111 at k+28, then `busy` drops.
3. At FORWARD 111_111, send REVERSE 110_110:
   - 1111 / 000000 during k..k+9, with `cmdReady`=0;
   - 1001 / 000000 at k+10;
   - 110_110 at k+34.
4. At FORWARD 111_111, send FORWARD 111_011: tread 1 steps 111→011 over 16 cycles while tread 2 holds 111, and direction never leaves 0110.
5. Mid-ramp, send HARD_STOP: 1111 / 000000 at the accept edge with `busy`=0. Then send code 0011: result is 0000 / 000000.
6. During RAMP, drive `currentSensing`=000001:
   - `fault`=1 and outputs 0000 / 000000 within 3 edges;
   - `faultClear` with current still high is ignored;
   - after current returns to 0, `faultClear` gives `fault`=0 and IDLE.

Source files
------------

// File: rtl/rover_drive_pkg.sv
// Shared definitions for the rover drive path: H-bridge direction codes,
// sequencer states and tread speed geometry.
package rover_drive_pkg;
  localparam int TREAD_W = 3;
  localparam int TREAD_N = 2;

  localparam logic [3:0] DIR_INERTIAL_STOP = 4'b0000;
  localparam logic [3:0] DIR_HARD_STOP     = 4'b1111;
  localparam logic [3:0] DIR_FORWARD       = 4'b0110;
  localparam logic [3:0] DIR_REVERSE       = 4'b1001;
  localparam logic [3:0] DIR_TURN_RIGHT    = 4'b0101;
  localparam logic [3:0] DIR_TURN_LEFT     = 4'b1010;

  typedef enum logic [1:0] {IDLE, RAMP, DEADTIME, FAULT} seqState_t;
  typedef logic [TREAD_N-1:0][TREAD_W-1:0] treadSpeed_t;

  function automatic logic isMotionDir(input logic [3:0] d);
    return d inside {DIR_FORWARD, DIR_REVERSE, DIR_TURN_RIGHT, DIR_TURN_LEFT};
  endfunction
endpackage

// File: rtl/drive_command_sequencer_if.sv
// Motion command valid/ready channel from the command decoder to the sequencer.
interface drive_command_sequencer_if;
  import rover_drive_pkg::*;
  logic        cmdValid;
  logic        cmdReady;
  logic [3:0]  cmdDirection;
  treadSpeed_t cmdSpeed;

  modport master (output cmdValid, cmdDirection, cmdSpeed, input cmdReady);
  modport slave  (input cmdValid, cmdDirection, cmdSpeed, output cmdReady);
endinterface

// File: rtl/tread_speed_ramp.sv
// One-tread speed stepper: moves one step toward target when strobed, saturating at target.
module tread_speed_ramp import rover_drive_pkg::*; (
  input  logic [TREAD_W-1:0] curSpeed,
  input  logic [TREAD_W-1:0] targetSpeed,
  input  logic               stepStrobe,
  output logic [TREAD_W-1:0] nextSpeed,
  output logic               atTarget
);
  always_comb begin
    nextSpeed = curSpeed;
    if (stepStrobe && (curSpeed < targetSpeed))      nextSpeed = curSpeed + TREAD_W'(1);
    else if (stepStrobe && (curSpeed > targetSpeed)) nextSpeed = curSpeed - TREAD_W'(1);
  end

  assign atTarget = (nextSpeed == targetSpeed);
endmodule

// File: rtl/drive_command_sequencer.sv
// H-bridge command sequencer: speed ramping, braked dead time on reversal,
// latched over-current shutdown.
module drive_command_sequencer import rover_drive_pkg::*; #(
  parameter int RAMP_DIV        = 2000,
  parameter int DEADTIME_CYCLES = 1000
) (
  input  logic                        clock,
  input  logic                        reset,
  drive_command_sequencer_if.slave    cmdIf,
  input  logic [5:0]                  currentSensing,
  input  logic                        faultClear,
  output logic [3:0]                  movingDirection,
  output treadSpeed_t                 motorSpeed,
  output logic                        busy,
  output logic                        fault
);
  localparam int CNT_MAX = (RAMP_DIV > DEADTIME_CYCLES) ? RAMP_DIV : DEADTIME_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  seqState_t             state, nState;
  logic [3:0]            nDir, pendDir, nPendDir, cmdDirEff;
  treadSpeed_t           nSpeed, target, nTarget, pendTarget, nPendTarget, rampSpeed;
  logic [CW-1:0]         cnt, nCnt;
  logic [1:0][5:0]       csSync;
  logic [TREAD_N-1:0]    atTarget;
  logic                  faultNow, accept, stepStrobe, cmdIsStop;

  assign faultNow   = |csSync[1];
  assign cmdIf.cmdReady = !reset && ((state == IDLE) || (state == RAMP));
  assign accept     = cmdIf.cmdValid && cmdIf.cmdReady;
  assign stepStrobe = (state == RAMP) && (cnt == CW'(RAMP_DIV - 1));

  // Unknown codes collapse to an inertial stop; hard stop passes through.
  assign cmdIsStop  = !isMotionDir(cmdIf.cmdDirection);
  assign cmdDirEff  = isMotionDir(cmdIf.cmdDirection) ? cmdIf.cmdDirection :
                      (cmdIf.cmdDirection == DIR_HARD_STOP) ? DIR_HARD_STOP : DIR_INERTIAL_STOP;

  for (genvar t = 0; t < TREAD_N; t++) begin : gTread
    tread_speed_ramp uRamp (
      .curSpeed    (motorSpeed[t]),
      .targetSpeed (target[t]),
      .stepStrobe  (stepStrobe),
      .nextSpeed   (rampSpeed[t]),
      .atTarget    (atTarget[t])
    );
  end

  always_comb begin
    nState      = state;
    nDir        = movingDirection;
    nSpeed      = motorSpeed;
    nTarget     = target;
    nCnt        = cnt;
    nPendDir    = pendDir;
    nPendTarget = pendTarget;
    if (faultNow) begin
      // Over-current wins over everything, including a same-edge handshake.
      nState      = FAULT;
      nDir        = DIR_INERTIAL_STOP;
      nSpeed      = '0;
      nTarget     = '0;
      nCnt        = '0;
      nPendDir    = '0;
      nPendTarget = '0;
    end else begin
      unique case (state)
        IDLE, RAMP: begin
          if (state == RAMP) begin
            nSpeed = rampSpeed;
            nCnt   = stepStrobe ? '0 : cnt + CW'(1);
            if (&atTarget) nState = IDLE;
          end
          if (accept) begin
            nCnt = '0;
            if (cmdIsStop) begin
              nDir    = cmdDirEff;
              nSpeed  = '0;
              nTarget = '0;
              nState  = IDLE;
            end else if (cmdDirEff == movingDirection) begin
              nSpeed  = motorSpeed;
              nTarget = cmdIf.cmdSpeed;
              nState  = RAMP;
            end else if (motorSpeed == '0) begin
              nDir    = cmdDirEff;
              nTarget = cmdIf.cmdSpeed;
              nState  = RAMP;
            end else begin
              nDir        = DIR_HARD_STOP;
              nSpeed      = '0;
              nTarget     = '0;
              nPendDir    = cmdDirEff;
              nPendTarget = cmdIf.cmdSpeed;
              nState      = DEADTIME;
            end
          end
        end
        DEADTIME: begin
          if (cnt == CW'(DEADTIME_CYCLES - 1)) begin
            nDir    = pendDir;
            nSpeed  = '0;
            nTarget = pendTarget;
            nCnt    = '0;
            nState  = RAMP;
          end else begin
            nCnt = cnt + CW'(1);
          end
        end
        FAULT: if (faultClear) nState = IDLE;
        default: nState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      movingDirection <= DIR_INERTIAL_STOP;
      motorSpeed      <= '0;
      target          <= '0;
      cnt             <= '0;
      pendDir         <= '0;
      pendTarget      <= '0;
      csSync          <= '0;
      busy            <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state           <= nState;
      movingDirection <= nDir;
      motorSpeed      <= nSpeed;
      target          <= nTarget;
      cnt             <= nCnt;
      pendDir         <= nPendDir;
      pendTarget      <= nPendTarget;
      csSync          <= {csSync[0], currentSensing};
      busy            <= (nState != IDLE);
      fault           <= (nState == FAULT);
    end
  end
endmodule

// File: tb/tb_drive_command_sequencer.sv
// Directed bench for drive_command_sequencer with a cycle-stamped expectation queue.
module tb_drive_command_sequencer;
  localparam int RD = 4;
  localparam int DT = 10;

  typedef struct {
    int         at;
    logic [3:0] dir;
    logic [5:0] spd;
    logic       busy;
    logic       ready;
    logic       fault;
    string      tag;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] currentSensing;
  logic       faultClear;
  logic [3:0] movingDirection;
  logic [5:0] motorSpeed;
  logic       busy, fault;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   k, k2;
  exp_t sb[$];

  drive_command_sequencer_if cmdIf ();

  drive_command_sequencer #(.RAMP_DIV(RD), .DEADTIME_CYCLES(DT)) dut (
    .clock           (clock),
    .reset           (reset),
    .cmdIf           (cmdIf.slave),
    .currentSensing  (currentSensing),
    .faultClear      (faultClear),
    .movingDirection (movingDirection),
    .motorSpeed      (motorSpeed),
    .busy            (busy),
    .fault           (fault)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] obsNow();
    return {19'b0, movingDirection, motorSpeed, busy, cmdIf.cmdReady, fault};
  endfunction

  function automatic logic [31:0] pack(logic [3:0] d, logic [5:0] s, logic b, logic r, logic f);
    return {19'b0, d, s, b, r, f};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic expectAt(int at, logic [3:0] d, logic [5:0] s, logic b, logic r, logic f, string tag);
    exp_t e;
    e.at = at; e.dir = d; e.spd = s; e.busy = b; e.ready = r; e.fault = f; e.tag = tag;
    sb.push_back(e);
  endtask

  // One clock edge, then retire every expectation stamped for this edge.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    cyc++;
    @(negedge clock);
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) check({e.tag, "_late"}, 32'(cyc), 32'(e.at));
      else check(e.tag, obsNow(), pack(e.dir, e.spd, e.busy, e.ready, e.fault));
    end
  endtask

  task automatic send(logic [3:0] d, logic [5:0] s);
    cmdIf.cmdValid     = 1'b1;
    cmdIf.cmdDirection = d;
    cmdIf.cmdSpeed     = s;
    tick();
    cmdIf.cmdValid     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] v;
    reset = 1'b1; currentSensing = '0; faultClear = 1'b0;
    cmdIf.cmdValid = 1'b0; cmdIf.cmdDirection = '0; cmdIf.cmdSpeed = '0;
    #1 check("rstHold", obsNow(), pack(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rstRelease", obsNow(), pack(4'b0000, 6'b0, 1'b0, 1'b1, 1'b0));

    // From stop: forward full speed ramps one step per RD cycles
    k = cyc + 1;
    expectAt(k, 4'b0110, 6'b0, 1'b1, 1'b1, 1'b0, "fwdDir");
    for (int j = 1; j <= 7; j++) begin
      v = 3'(j);
      expectAt(k + RD*j, 4'b0110, {v, v}, (j < 7), 1'b1, 1'b0, "fwdRamp");
    end
    send(4'b0110, 6'b111_111);
    repeat (28) tick();
    tick();

    // Same direction retarget: only tread 1 ramps down
    k = cyc + 1;
    expectAt(k, 4'b0110, 6'b111_111, 1'b1, 1'b1, 1'b0, "retgtHold");
    for (int j = 1; j <= 4; j++) begin
      v = 3'(7 - j);
      expectAt(k + RD*j, 4'b0110, {3'b111, v}, (j < 4), 1'b1, 1'b0, "retgtStep");
    end
    send(4'b0110, 6'b111_011);
    repeat (16) tick();
    tick();

    k = cyc + 1;
    expectAt(k, 4'b0110, 6'b111_011, 1'b1, 1'b1, 1'b0, "reupHold");
    for (int j = 1; j <= 4; j++) begin
      v = 3'(3 + j);
      expectAt(k + RD*j, 4'b0110, {3'b111, v}, (j < 4), 1'b1, 1'b0, "reupStep");
    end
    send(4'b0110, 6'b111_111);
    repeat (16) tick();
    tick();

    // Reversal at speed: braked dead time, then ramp from zero
    k = cyc + 1;
    expectAt(k,      4'b1111, 6'b0, 1'b1, 1'b0, 1'b0, "revBrake");
    expectAt(k+DT-1, 4'b1111, 6'b0, 1'b1, 1'b0, 1'b0, "revBrakeEnd");
    expectAt(k+DT,   4'b1001, 6'b0, 1'b1, 1'b1, 1'b0, "revDir");
    for (int j = 1; j <= 6; j++) begin
      v = 3'(j);
      expectAt(k + DT + RD*j, 4'b1001, {v, v}, (j < 6), 1'b1, 1'b0, "revRamp");
    end
    send(4'b1001, 6'b110_110);
    repeat (34) tick();
    tick();

    // Hard stop mid-ramp, then an unknown code
    k = cyc + 1;
    expectAt(k,    4'b1001, 6'b110_110, 1'b1, 1'b1, 1'b0, "slowHold");
    expectAt(k+RD, 4'b1001, 6'b101_101, 1'b1, 1'b1, 1'b0, "slowStep");
    send(4'b1001, 6'b000_000);
    repeat (5) tick();
    k2 = cyc + 1;
    expectAt(k2, 4'b1111, 6'b0, 1'b0, 1'b1, 1'b0, "hardStop");
    send(4'b1111, 6'b111_111);
    k2 = cyc + 1;
    expectAt(k2, 4'b0000, 6'b0, 1'b0, 1'b1, 1'b0, "badCode");
    send(4'b0011, 6'b111_111);
    tick();

    // Asynchronous reset mid-ramp
    k = cyc + 1;
    expectAt(k + 2*RD, 4'b0110, 6'b010_010, 1'b1, 1'b1, 1'b0, "preRst");
    send(4'b0110, 6'b111_111);
    repeat (2*RD) tick();
    reset = 1'b1;
    #1 check("rstAsync", obsNow(), pack(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0));
    tick();
    reset = 1'b0;
    tick();
    check("rstReady", obsNow(), pack(4'b0000, 6'b0, 1'b0, 1'b1, 1'b0));
    repeat (6) tick();
    check("rstLost", obsNow(), pack(4'b0000, 6'b0, 1'b0, 1'b1, 1'b0));

    // Over-current during ramp
    k = cyc + 1;
    expectAt(k,    4'b0110, 6'b0,       1'b1, 1'b1, 1'b0, "fltPre");
    expectAt(k+RD, 4'b0110, 6'b001_001, 1'b1, 1'b1, 1'b0, "fltStep");
    expectAt(k+7,  4'b0110, 6'b001_001, 1'b1, 1'b1, 1'b0, "fltSync");
    expectAt(k+8,  4'b0000, 6'b0,       1'b1, 1'b0, 1'b1, "fltHit");
    send(4'b0110, 6'b111_111);
    repeat (5) tick();
    currentSensing = 6'b000001;
    repeat (3) tick();
    faultClear = 1'b1;
    expectAt(cyc + 1, 4'b0000, 6'b0, 1'b1, 1'b0, 1'b1, "clrIgnored");
    tick();
    faultClear = 1'b0;
    currentSensing = '0;
    repeat (3) tick();
    faultClear = 1'b1;
    expectAt(cyc + 1, 4'b0000, 6'b0, 1'b0, 1'b1, 1'b0, "clrOk");
    tick();
    faultClear = 1'b0;
    tick();

    check("sbDrain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
